// File: rtl/dmem_access_if.sv
// Physical data-bus bundle between the data-memory access stage and memory.
// The master side issues word transactions; the slave side accepts them and
// returns read data.
interface dmem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_access.sv
// Data-memory access stage sitting directly after the TLB. Takes the TLB's
// physical address and fault code with a load/store request, performs at most
// one word transaction on the 18-bit physical bus, and hands load data or a
// fault code to writeback. The pipeline is stalled while a transaction is open.
// Optional feature: define MEM_TIMEOUT_EN to abort a bus transaction that has
// spent TIMEOUT_CYCLES cycles in REQ/WAIT, reporting BUSERR_EXC.
module dmem_access #(
`ifdef MEM_TIMEOUT_EN
  parameter logic [7:0] BUSERR_EXC     = 8'h85,
  parameter int         TIMEOUT_CYCLES = 64,
`endif
  parameter logic [7:0] MISALIGN_EXC   = 8'h84
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        in_valid,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  input  logic [17:0] paddr,
  input  logic [7:0]  exc_in,
  dmem_access_if.master bus,
  output logic        stall,
  output logic        out_valid,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  output logic [7:0]  out_exc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state;
  logic [4:0]  lat_rd;
  logic [1:0]  lat_lo;
  logic        lat_byte;
  logic        lat_half;
  logic        lat_signed;

  logic        is_byte;
  logic        is_half;
  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] shifted;
  logic [31:0] load_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] to_cnt;
  logic          timeout_hit;
  assign timeout_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Decode the incoming request: alignment check, byte lanes and replicated store data.
  always_comb begin
    is_byte    = (in_size == 2'd0);
    is_half    = (in_size == 2'd1);
    misalign   = (is_half && paddr[0]) || (!is_byte && !is_half && (paddr[1:0] != 2'b00));
    be_calc    = 4'b1111;
    wdata_calc = in_wdata;
    if (is_byte) begin
      be_calc    = 4'b0001 << paddr[1:0];
      wdata_calc = {4{in_wdata[7:0]}};
    end else if (is_half) begin
      be_calc    = 4'b0011 << paddr[1:0];
      wdata_calc = {2{in_wdata[15:0]}};
    end
  end

  // Pull the addressed lane out of the returned word and extend it to 32 bits.
  always_comb begin
    shifted   = bus.mem_rdata >> {lat_lo, 3'b000};
    load_data = shifted;
    if (lat_byte) begin
      load_data = {{24{lat_signed & shifted[7]}}, shifted[7:0]};
    end else if (lat_half) begin
      load_data = {{16{lat_signed & shifted[15]}}, shifted[15:0]};
    end
  end

  // Access FSM: accepts requests in IDLE, holds the bus request in REQ, collects read data in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      stall         <= 1'b0;
      out_valid     <= 1'b0;
      out_rd        <= '0;
      out_data      <= '0;
      out_exc       <= '0;
      lat_rd        <= '0;
      lat_lo        <= '0;
      lat_byte      <= 1'b0;
      lat_half      <= 1'b0;
      lat_signed    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else if (clk_en) begin
      out_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      to_cnt <= (state == IDLE) ? '0 : to_cnt + CW'(1);
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (exc_in != 8'h00) begin
              out_valid <= 1'b1;
              out_exc   <= exc_in;
              out_data  <= '0;
              out_rd    <= in_rd;
            end else if (misalign) begin
              out_valid <= 1'b1;
              out_exc   <= MISALIGN_EXC;
              out_data  <= '0;
              out_rd    <= in_rd;
            end else if (!in_read && !in_write) begin
              out_valid <= 1'b1;
              out_exc   <= 8'h00;
              out_data  <= '0;
              out_rd    <= in_rd;
            end else begin
              state         <= REQ;
              stall         <= 1'b1;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= in_write;
              bus.mem_addr  <= paddr[17:2];
              bus.mem_be    <= be_calc;
              bus.mem_wdata <= wdata_calc;
              lat_rd        <= in_rd;
              lat_lo        <= paddr[1:0];
              lat_byte      <= is_byte;
              lat_half      <= is_half;
              lat_signed    <= in_signed;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            if (bus.mem_we) begin
              state     <= IDLE;
              stall     <= 1'b0;
              out_valid <= 1'b1;
              out_exc   <= 8'h00;
              out_data  <= '0;
              out_rd    <= lat_rd;
            end else begin
              state <= WAIT;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            bus.mem_req <= 1'b0;
            state       <= IDLE;
            stall       <= 1'b0;
            out_valid   <= 1'b1;
            out_exc     <= BUSERR_EXC;
            out_data    <= '0;
            out_rd      <= lat_rd;
          end
`endif
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            state     <= IDLE;
            stall     <= 1'b0;
            out_valid <= 1'b1;
            out_exc   <= 8'h00;
            out_data  <= load_data;
            out_rd    <= lat_rd;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_hit) begin
            state     <= IDLE;
            stall     <= 1'b0;
            out_valid <= 1'b1;
            out_exc   <= BUSERR_EXC;
            out_data  <= '0;
            out_rd    <= lat_rd;
          end
`endif
        end
        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
